batcharger_ctrl: RTL
====================

Name: batcharger_ctrl

Overview:
Digital charge controller for the LiPo battery charger front-end. It sequences the monitor ADC over battery voltage, battery current and battery temperature, and runs the trickle/CC/CV/end-of-charge state machine. It drives the analog charger's mode enables and DAC target codes. It sits on the dvdd domain between the monitor ADC and the BATCHARGER_64b analog power stage.

Parameters:
VTRICKLE, 153, vbat code below which trickle charge is used (3.0 V; vbat LSB = 5/255 V)
VCUTOFF, 214, vbat code for CC->CV transition and CV target (4.2 V)
VRECHARGE, 204, vbat code below which DONE restarts charging (4.0 V)
TMAX, 125, vtbat code above which charging faults
TMIN, 0, vtbat code below which charging faults
THYST, 5, vtbat codes of hysteresis to leave FAULT
CVTMO, 1000000, clk cycles allowed in CV before forced DONE

Ports:
clk  in  1  controller clock
rstz  in  1  asynchronous active-low reset
en  in  1  charger enable
sel  in  4  capacity select; capacity = 50*(sel+1) mAh
adc_req  out  1  conversion request
adc_ch  out  2  channel: 0 = vbat, 1 = ibat, 2 = vtbat
adc_ack  in  1  conversion complete; adc_data valid this cycle
adc_data  in  8  conversion result
tc_en  out  1  trickle-current mode
cc_en  out  1  constant-current mode
cv_en  out  1  constant-voltage mode
icode  out  8  current target (LSB 5 mA)
vcode  out  8  voltage target (LSB 5/255 V)
done  out  1  charge complete
fault  out  1  temperature fault

Behaviour:
- Reset (rstz low, async): state OFF, all outputs 0, adc_ch 0, sample registers 0, timer 0.
- ADC handshake:
  - adc_req rises with adc_ch stable.
  - adc_ch is held until adc_ack.
  - adc_data is captured on the ack cycle.
  - adc_req drops the next cycle.
  - One idle cycle follows, then the next request.
  - Channel order is 0, 1, 2, repeat.
  - scan_done pulses one cycle after the channel-2 capture. State decisions are made only on scan_done, using the latest vbat/ibat/vtbat.
  - adc_ack while adc_req is low is ignored.
- Scanning runs in every state except OFF.
- Capacity: on OFF->START, latch k = sel+1.
  - I_CC = 5*k (0.5C).
  - I_TC = k (0.1C).
  - ITERM = ceil(k/2) (C/20).
- FSM (on scan_done unless noted):
  - OFF: en=1 -> START, next cycle.
  - START: waits for the first scan_done, then:
    - fault condition -> FAULT
    - else vbat < VTRICKLE -> TRICKLE
    - else vbat < VCUTOFF -> CC
    - else -> CV
  - TRICKLE: tc_en=1, icode=I_TC. vbat >= VTRICKLE -> CC.
  - CC: cc_en=1, icode=I_CC. vbat >= VCUTOFF -> CV.
  - CV: cv_en=1, vcode=VCUTOFF, icode=I_CC (current limit). The timer counts every cycle. Exit to DONE when ibat <= ITERM, or when the timer reaches CVTMO (checked every cycle, not only on scan_done). The timer clears on CV entry.
  - DONE: done=1, all mode enables 0. vbat < VRECHARGE -> START.
  - FAULT: fault=1, enables 0. vtbat <= TMAX-THYST and vtbat >= TMIN+THYST -> START.
  - Fault condition: vtbat > TMAX or vtbat < TMIN. It is evaluated in TRICKLE/CC/CV/DONE and takes priority over every other transition.
- en=0 in any state: OFF on the next cycle, adc_req dropped immediately (an in-flight conversion is abandoned, and a late ack is ignored), all outputs 0.
- sel changes outside OFF are ignored until the next START entry from OFF.
- Exactly one of tc_en/cc_en/cv_en is high at a time, and only in the matching state. done and fault are mutually exclusive.
- Comparisons are unsigned 8-bit. I_CC at most 80, so there is no overflow.

Decomposition:
- batcharger_pkg holds:
  - state enum (OFF, START, TRICKLE, CC, CV, DONE, FAULT)
  - channel constants
  - default threshold constants
  - functions for I_CC/I_TC/ITERM from k
- Sub-module batcharger_adc_seq holds the request/ack handshake, channel rotation, sample registers and scan_done. Its abort input is driven from en=0.

Test Plan:
- Full charge: sel=4'b1000 (k=9), vbat=140, ibat=9, vtbat=100 -> START, then TRICKLE with icode=9. vbat=170 -> CC, icode=45. vbat=214 -> CV, vcode=214. ibat=5 -> DONE, done=1.
- Recharge: from DONE, vbat=181 (3.55 V) -> START, then CC with cc_en=1 after the next scan. vbat=210 in DONE -> stays DONE.
- Temperature exit: in CC, vtbat=140 -> FAULT after scan_done, all enables 0, fault=1. vtbat=122 -> stays FAULT. vtbat=100 -> START.
- Disable: in CV mid-conversion, en=0 -> next cycle OFF, adc_req=0, outputs 0. A late adc_ack produces no capture. en=1 -> START with sel re-latched.
- CV timeout: CVTMO=50, ibat held at 40 -> DONE exactly 50 cycles after CV entry.
- Handshake: ack delayed 0 to 7 cycles -> adc_ch stable while adc_req is high, channel order 0,1,2, and one idle cycle between requests.

Source files
------------

// File: rtl/batcharger_pkg.sv
// Shared definitions for the battery charge controller: FSM state encoding,
// monitor-ADC channel codes, default charge thresholds and the helpers that
// derive the charge currents from the latched capacity factor k.
package batcharger_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_START   = 3'd1,
    ST_TRICKLE = 3'd2,
    ST_CC      = 3'd3,
    ST_CV      = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  // Monitor ADC channel selects
  localparam logic [1:0] CH_VBAT  = 2'd0;
  localparam logic [1:0] CH_IBAT  = 2'd1;
  localparam logic [1:0] CH_VTBAT = 2'd2;

  // Default thresholds (vbat LSB = 5/255 V, vtbat in raw sensor codes)
  localparam logic [7:0] DEF_VTRICKLE  = 8'd153;
  localparam logic [7:0] DEF_VCUTOFF   = 8'd214;
  localparam logic [7:0] DEF_VRECHARGE = 8'd204;
  localparam logic [7:0] DEF_TMAX      = 8'd125;
  localparam logic [7:0] DEF_TMIN      = 8'd0;
  localparam logic [7:0] DEF_THYST     = 8'd5;
  localparam int         DEF_CVTMO     = 1000000;

  // Constant-current target: 0.5C = 5*k (k <= 16, so at most 80)
  function automatic logic [7:0] i_cc_f(input logic [4:0] k);
    return {3'b000, k} * 8'd5;
  endfunction

  // Trickle-current target: 0.1C = k
  function automatic logic [7:0] i_tc_f(input logic [4:0] k);
    return {3'b000, k};
  endfunction

  // Termination current: C/20 = ceil(k/2)
  function automatic logic [7:0] iterm_f(input logic [4:0] k);
    logic [5:0] kp1;
    kp1 = {1'b0, k} + 6'd1;
    return {3'b000, kp1[5:1]};
  endfunction

  // Unsigned 8-bit less-than, kept as a function so a zero bound is legal
  function automatic logic lt_u8(input logic [7:0] a, input logic [7:0] b);
    return (a < b);
  endfunction

endpackage

// File: rtl/batcharger_adc_seq.sv
// Monitor-ADC sequencer: rotates vbat -> ibat -> vtbat, runs the req/ack
// handshake with one idle cycle between requests, keeps the latest sample of
// each channel and pulses scan_done the cycle after the vtbat capture.
module batcharger_adc_seq
  import batcharger_pkg::*;
(
  input  logic       clk,
  input  logic       rstz,
  input  logic       run,
  input  logic       abort,
  output logic       adc_req,
  output logic [1:0] adc_ch,
  input  logic       adc_ack,
  input  logic [7:0] adc_data,
  output logic [7:0] vbat,
  output logic [7:0] ibat,
  output logic [7:0] vtbat,
  output logic       scan_done
);

  typedef enum logic [1:0] {
    SQ_IDLE = 2'd0,
    SQ_REQ  = 2'd1,
    SQ_GAP  = 2'd2
  } seq_t;

  seq_t       sq_r;
  logic       req_r;
  logic [1:0] ch_r;
  logic [7:0] vbat_r;
  logic [7:0] ibat_r;
  logic [7:0] vtbat_r;
  logic       scan_done_r;
  logic       capture_s;

  // Abort kills the request in the same cycle; acks without a live request are dropped
  assign adc_req   = req_r & ~abort;
  assign adc_ch    = ch_r;
  assign capture_s = req_r & adc_ack & ~abort;
  assign vbat      = vbat_r;
  assign ibat      = ibat_r;
  assign vtbat     = vtbat_r;
  assign scan_done = scan_done_r;

  // Handshake sequencing and channel rotation
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      sq_r        <= SQ_IDLE;
      req_r       <= 1'b0;
      ch_r        <= CH_VBAT;
      scan_done_r <= 1'b0;
    end else begin
      scan_done_r <= 1'b0;
      if (!run || abort) begin
        sq_r  <= SQ_IDLE;
        req_r <= 1'b0;
        ch_r  <= CH_VBAT;
      end else begin
        case (sq_r)
          SQ_IDLE: begin
            req_r <= 1'b1;
            sq_r  <= SQ_REQ;
          end
          SQ_REQ: begin
            if (adc_ack) begin
              req_r       <= 1'b0;
              sq_r        <= SQ_GAP;
              ch_r        <= (ch_r == CH_VTBAT) ? CH_VBAT : ch_r + 2'd1;
              scan_done_r <= (ch_r == CH_VTBAT);
            end else begin
              req_r <= 1'b1;
            end
          end
          SQ_GAP: begin
            req_r <= 1'b1;
            sq_r  <= SQ_REQ;
          end
          default: begin
            sq_r  <= SQ_IDLE;
            req_r <= 1'b0;
            ch_r  <= CH_VBAT;
          end
        endcase
      end
    end
  end

  // Sample registers, written only on an accepted ack
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      vbat_r  <= 8'd0;
      ibat_r  <= 8'd0;
      vtbat_r <= 8'd0;
    end else if (capture_s) begin
      case (ch_r)
        CH_VBAT:  vbat_r  <= adc_data;
        CH_IBAT:  ibat_r  <= adc_data;
        CH_VTBAT: vtbat_r <= adc_data;
        default:  vbat_r  <= vbat_r;
      endcase
    end else begin
      vbat_r <= vbat_r;
    end
  end

endmodule

// File: rtl/batcharger_ctrl.sv
// LiPo charge controller: trickle / constant-current / constant-voltage /
// end-of-charge sequencing with temperature fault, driving the analog
// charger's mode enables and DAC target codes from monitor ADC samples.
module batcharger_ctrl
  import batcharger_pkg::*;
#(
  parameter logic [7:0] VTRICKLE  = DEF_VTRICKLE,
  parameter logic [7:0] VCUTOFF   = DEF_VCUTOFF,
  parameter logic [7:0] VRECHARGE = DEF_VRECHARGE,
  parameter logic [7:0] TMAX      = DEF_TMAX,
  parameter logic [7:0] TMIN      = DEF_TMIN,
  parameter logic [7:0] THYST     = DEF_THYST,
  parameter int         CVTMO     = DEF_CVTMO
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       en,
  input  logic [3:0] sel,
  output logic       adc_req,
  output logic [1:0] adc_ch,
  input  logic       adc_ack,
  input  logic [7:0] adc_data,
  output logic       tc_en,
  output logic       cc_en,
  output logic       cv_en,
  output logic [7:0] icode,
  output logic [7:0] vcode,
  output logic       done,
  output logic       fault
);

  localparam int              TW       = (CVTMO > 1) ? $clog2(CVTMO) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(CVTMO - 1);
  localparam logic [7:0]      TCLR_HI  = TMAX - THYST;
  localparam logic [7:0]      TCLR_LO  = TMIN + THYST;

  state_t        state_r;
  state_t        next_s;
  logic [4:0]    k_r;
  logic [TW-1:0] timer_r;
  logic          run_s;
  logic          abort_s;
  logic          scan_done_s;
  logic [7:0]    vbat_s;
  logic [7:0]    ibat_s;
  logic [7:0]    vtbat_s;
  logic          fault_cond_s;
  logic          fault_clear_s;
  logic          timeout_s;
  logic [7:0]    iterm_s;

  assign run_s   = en & (state_r != ST_OFF);
  assign abort_s = ~en;

  batcharger_adc_seq u_adc (
    .clk       (clk),
    .rstz      (rstz),
    .run       (run_s),
    .abort     (abort_s),
    .adc_req   (adc_req),
    .adc_ch    (adc_ch),
    .adc_ack   (adc_ack),
    .adc_data  (adc_data),
    .vbat      (vbat_s),
    .ibat      (ibat_s),
    .vtbat     (vtbat_s),
    .scan_done (scan_done_s)
  );

  assign fault_cond_s  = (vtbat_s > TMAX) | lt_u8(vtbat_s, TMIN);
  assign fault_clear_s = (vtbat_s <= TCLR_HI) & ~lt_u8(vtbat_s, TCLR_LO);
  assign timeout_s     = (timer_r == TMO_LAST);
  assign iterm_s       = iterm_f(k_r);

  // Next-state decision; fault checks outrank every other move
  always_comb begin
    next_s = state_r;
    if (!en) begin
      next_s = ST_OFF;
    end else begin
      case (state_r)
        ST_OFF: next_s = ST_START;
        ST_START: begin
          if (!scan_done_s)             next_s = ST_START;
          else if (fault_cond_s)        next_s = ST_FAULT;
          else if (vbat_s < VTRICKLE)   next_s = ST_TRICKLE;
          else if (vbat_s < VCUTOFF)    next_s = ST_CC;
          else                          next_s = ST_CV;
        end
        ST_TRICKLE: begin
          if (!scan_done_s)             next_s = ST_TRICKLE;
          else if (fault_cond_s)        next_s = ST_FAULT;
          else if (vbat_s >= VTRICKLE)  next_s = ST_CC;
          else                          next_s = ST_TRICKLE;
        end
        ST_CC: begin
          if (!scan_done_s)             next_s = ST_CC;
          else if (fault_cond_s)        next_s = ST_FAULT;
          else if (vbat_s >= VCUTOFF)   next_s = ST_CV;
          else                          next_s = ST_CC;
        end
        ST_CV: begin
          // The timeout is watched every cycle, the current taper only per scan
          if (scan_done_s && fault_cond_s)               next_s = ST_FAULT;
          else if (timeout_s)                            next_s = ST_DONE;
          else if (scan_done_s && (ibat_s <= iterm_s))   next_s = ST_DONE;
          else                                           next_s = ST_CV;
        end
        ST_DONE: begin
          if (!scan_done_s)             next_s = ST_DONE;
          else if (fault_cond_s)        next_s = ST_FAULT;
          else if (vbat_s < VRECHARGE)  next_s = ST_START;
          else                          next_s = ST_DONE;
        end
        ST_FAULT: begin
          if (scan_done_s && fault_clear_s) next_s = ST_START;
          else                              next_s = ST_FAULT;
        end
        default: next_s = ST_OFF;
      endcase
    end
  end

  // State, capacity latch, CV timer and registered charger outputs
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_r <= ST_OFF;
      k_r     <= 5'd0;
      timer_r <= '0;
      tc_en   <= 1'b0;
      cc_en   <= 1'b0;
      cv_en   <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
      icode   <= 8'd0;
      vcode   <= 8'd0;
    end else begin
      state_r <= next_s;

      // Capacity is sampled only when charging starts from OFF
      if ((state_r == ST_OFF) && (next_s == ST_START)) begin
        k_r <= {1'b0, sel} + 5'd1;
      end else begin
        k_r <= k_r;
      end

      if ((next_s == ST_CV) && (state_r != ST_CV)) begin
        timer_r <= '0;
      end else if (state_r == ST_CV) begin
        timer_r <= timer_r + TW'(1);
      end else begin
        timer_r <= timer_r;
      end

      tc_en <= (next_s == ST_TRICKLE);
      cc_en <= (next_s == ST_CC);
      cv_en <= (next_s == ST_CV);
      done  <= (next_s == ST_DONE);
      fault <= (next_s == ST_FAULT);
      vcode <= (next_s == ST_CV) ? VCUTOFF : 8'd0;
      case (next_s)
        ST_TRICKLE:   icode <= i_tc_f(k_r);
        ST_CC, ST_CV: icode <= i_cc_f(k_r);
        default:      icode <= 8'd0;
      endcase
    end
  end

endmodule
